// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared line/beat geometry and the line-serializer state
//                encoding used by the cache write path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

   // Default geometry, shared with the line queue instantiation.
   localparam int LINE_WIDTH     = 512;
   localparam int BEAT_WIDTH_DEF = 64;
   localparam int LINE_BEATS     = LINE_WIDTH / BEAT_WIDTH_DEF;
   localparam int BEAT_IDX_WIDTH = $clog2(LINE_BEATS);

   // Serializer control states.
   typedef enum logic [1:0] {
      SER_IDLE = 2'd0,
      SER_LOAD = 2'd1,
      SER_SEND = 2'd2
   } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/queue_line_serializer.sv
// ============================================================================
//  Module      : queue_line_serializer
//  Description : Pops one line at a time from the line queue and streams it
//                as BEAT_WIDTH-bit beats (LSB beat first) on a valid/ready
//                channel; counts completed lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_line_serializer
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH  = LINE_WIDTH,
   parameter int BEAT_WIDTH  = BEAT_WIDTH_DEF,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   q_empty,
   output logic                   q_deq,
   input  logic [DATA_WIDTH-1:0]  q_data,
   output logic                   beat_valid,
   input  logic                   beat_ready,
   output logic [BEAT_WIDTH-1:0]  beat_data,
   output logic                   beat_last,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] lines_done
);

   localparam int BEATS     = DATA_WIDTH / BEAT_WIDTH;
   localparam int IDX_WIDTH = $clog2(BEATS);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BEATS - 1);

   ser_state_e                          state_q, state_d;
   logic [IDX_WIDTH-1:0]                idx_q, idx_d;
   logic [DATA_WIDTH-1:0]               line_q, line_d;
   logic [COUNT_WIDTH-1:0]              count_q, count_d;
   logic                                w_deq;
   logic [BEATS-1:0][BEAT_WIDTH-1:0]    w_lanes;

   // The line register viewed as an array of beats; lane 0 is the LSB beat.
   assign w_lanes = line_q;

   // State, beat index, captured line and completed-line counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SER_IDLE;
         idx_q   <= '0;
         line_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         line_q  <= line_d;
         count_q <= count_d;
      end
   end

   // Next-state, beat advance and pop decision; start overrides everything.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      line_d  = line_q;
      count_d = count_q;
      w_deq   = 1'b0;

      case (state_q)
         SER_IDLE: begin
            if (!q_empty) begin
               w_deq   = 1'b1;
               state_d = SER_LOAD;
            end
         end
         SER_LOAD: begin
            // The queue presents the popped line one cycle after q_deq.
            line_d  = q_data;
            idx_d   = '0;
            state_d = SER_SEND;
         end
         SER_SEND: begin
            if (beat_ready) begin
               if (idx_q == LAST_IDX) begin
                  count_d = count_q + 1'b1;
                  idx_d   = '0;
                  // Pop the next line straight away; the LOAD cycle that
                  // follows keeps pops at least one cycle apart.
                  if (!q_empty) begin
                     w_deq   = 1'b1;
                     state_d = SER_LOAD;
                  end else begin
                     state_d = SER_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = SER_IDLE;
      endcase

      if (start) begin
         state_d = SER_IDLE;
         idx_d   = '0;
         line_d  = '0;
         count_d = '0;
         w_deq   = 1'b0;
      end
   end

   // Gate the pop with reset so every output reads 0 while reset is held.
   assign q_deq      = w_deq & reset;
   assign beat_valid = (state_q == SER_SEND);
   assign beat_data  = beat_valid ? w_lanes[idx_q] : '0;
   assign beat_last  = beat_valid && (idx_q == LAST_IDX);
   assign busy       = (state_q != SER_IDLE);
   assign lines_done = count_q;

endmodule

`default_nettype wire

// File: tb/tb_queue_line_serializer.sv
// ============================================================================
//  Module      : tb_queue_line_serializer
//  Description : Self-checking bench for queue_line_serializer with a
//                behavioural line queue and a beat scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_queue_line_serializer;

   localparam int DW  = 512;
   localparam int BW  = 64;
   localparam int NB  = DW / BW;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          q_empty;
   logic          q_deq;
   logic [DW-1:0] q_data;
   logic          beat_valid;
   logic          beat_ready;
   logic [BW-1:0] beat_data;
   logic          beat_last;
   logic          busy;
   logic [CW-1:0] lines_done;

   queue_line_serializer #(
      .DATA_WIDTH  (DW),
      .BEAT_WIDTH  (BW),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .q_empty    (q_empty),
      .q_deq      (q_deq),
      .q_data     (q_data),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_data  (beat_data),
      .beat_last  (beat_last),
      .busy       (busy),
      .lines_done (lines_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] d;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] line;
      int            stall_beat;
      int            stall_len;
      bit            rnd;
      logic [CW-1:0] exp_done;
   } vec_t;

   // Queue model and scoreboard state.
   logic [DW-1:0] lq[$];
   beat_t         sbq[$];
   bit            pend, prev_deq, prev_stall, hold_rdy, rand_rdy;
   logic [BW-1:0] prev_data;
   logic          prev_last;
   int            total, bad, cyc, n_deq, n_hs, line_beats, n_bubble;
   int            last_hs_cyc, last_hs_gap;
   int            stall_beat, stall_len, stall_cnt;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [DW-1:0] line);
      lq.push_back(line);
      for (int k = 0; k < NB; k++) begin
         beat_t b;
         b.d    = line[k*BW +: BW];
         b.last = (k == NB - 1);
         sbq.push_back(b);
      end
      q_empty = 1'b0;
   endtask

   task automatic wait_idle(input string name, input logic [CW-1:0] exp);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(lines_done == exp && !busy) && n < 400);
      chk({name, "_done"}, 64'(lines_done), 64'(exp));
      chk({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_beats(input string name, input int nb);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (line_beats != nb && n < 100);
      chk({name, "_reach"}, 64'(line_beats), 64'(nb));
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] l;
      for (int k = 0; k < DW / 32; k++) l[k*32 +: 32] = $urandom();
      return l;
   endfunction

   vec_t          vt[4];
   logic [DW-1:0] lane_line;
   int            d0, h0;

   initial begin
      total = 0; bad = 0; cyc = 0; n_deq = 0; n_hs = 0; line_beats = 0;
      n_bubble = 0; last_hs_cyc = 0; last_hs_gap = 0;
      pend = 0; prev_deq = 0; prev_stall = 0; hold_rdy = 0; rand_rdy = 0;
      prev_data = '0; prev_last = 0;
      stall_beat = -1; stall_len = 0; stall_cnt = 0;
      reset = 1'b0; start = 1'b0; q_empty = 1'b1; q_data = '0; beat_ready = 1'b0;

      // Queue model, ready generator and beat monitor.
      fork
         forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
               line_beats = 0; prev_deq = 0; prev_stall = 0;
            end else begin
               if (q_deq) begin
                  n_deq++;
                  chk("deq_nonempty", 64'(q_empty), 64'd0);
                  chk("deq_not_back_to_back", 64'(prev_deq), 64'd0);
                  pend = 1;
               end
               prev_deq = q_deq;
               if (prev_stall && !start) begin
                  chk("hold_valid", 64'(beat_valid), 64'd1);
                  chk("hold_data", beat_data, prev_data);
                  chk("hold_last", 64'(beat_last), 64'(prev_last));
               end
               prev_stall = beat_valid && !beat_ready && !start;
               prev_data  = beat_data;
               prev_last  = beat_last;
               if (busy && !beat_valid) n_bubble++;
               if (start) begin
                  line_beats = 0;
               end else if (beat_valid && beat_ready) begin
                  n_hs++;
                  if (sbq.size() == 0) begin
                     chk("sb_underflow", 64'd1, 64'd0);
                  end else begin
                     beat_t e;
                     e = sbq.pop_front();
                     chk("beat_data", beat_data, e.d);
                     chk("beat_last", 64'(beat_last), 64'(e.last));
                  end
                  if (beat_last) begin
                     line_beats  = 0;
                     last_hs_gap = cyc - last_hs_cyc;
                     last_hs_cyc = cyc;
                  end else begin
                     line_beats++;
                  end
               end
            end
            @(posedge clk);
            #1;
            if (pend) begin
               if (lq.size() != 0) q_data = lq.pop_front();
               pend = 0;
            end
            q_empty = (lq.size() == 0);
            if (hold_rdy) begin
               beat_ready = 1'b0;
            end else if (stall_beat >= 0 && beat_valid && line_beats == stall_beat
                         && stall_cnt < stall_len) begin
               beat_ready = 1'b0;
               stall_cnt++;
            end else if (rand_rdy) begin
               beat_ready = ($urandom_range(0, 3) != 0);
            end else begin
               beat_ready = 1'b1;
            end
         end
      join_none

      // Reset state.
      #1;
      chk("rst_valid", 64'(beat_valid), 64'd0);
      chk("rst_data", beat_data, 64'd0);
      chk("rst_last", 64'(beat_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(lines_done), 64'd0);
      chk("rst_deq", 64'(q_deq), 64'd0);
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Vector table: lane k = k+1 line, stalled line, random ready, stall on last beat.
      for (int k = 0; k < NB; k++) lane_line[k*BW +: BW] = 64'(k + 1);
      vt[0] = '{line: lane_line,  stall_beat: -1, stall_len: 0, rnd: 1'b0, exp_done: 4'd1};
      vt[1] = '{line: lane_line,  stall_beat: 2,  stall_len: 4, rnd: 1'b0, exp_done: 4'd2};
      vt[2] = '{line: '1,         stall_beat: -1, stall_len: 0, rnd: 1'b1, exp_done: 4'd3};
      vt[3] = '{line: rand_line(), stall_beat: 7, stall_len: 3, rnd: 1'b0, exp_done: 4'd4};
      for (int i = 0; i < 4; i++) begin
         d0 = n_deq; h0 = n_hs;
         stall_beat = vt[i].stall_beat; stall_len = vt[i].stall_len; stall_cnt = 0;
         rand_rdy = vt[i].rnd;
         push(vt[i].line);
         wait_idle("vec", vt[i].exp_done);
         chk("vec_deq_count", 64'(n_deq - d0), 64'd1);
         chk("vec_beats", 64'(n_hs - h0), 64'(NB));
         chk("vec_stall_cycles", 64'(stall_cnt), 64'(vt[i].stall_len));
         chk("vec_sb_empty", 64'(sbq.size()), 64'd0);
      end
      stall_beat = -1; rand_rdy = 0;

      // Three lines back-to-back: one LOAD bubble per line, BEATS+1 per line.
      start = 1'b1; tick(); start = 1'b0;
      chk("A_clear", 64'(lines_done), 64'd0);
      d0 = n_deq; n_bubble = 0;
      push(rand_line()); push(rand_line()); push(rand_line());
      wait_idle("A", 4'd3);
      chk("A_deq_count", 64'(n_deq - d0), 64'd3);
      chk("A_bubbles", 64'(n_bubble), 64'd3);
      chk("A_line_period", 64'(last_hs_gap), 64'(NB + 1));

      // Queue empty at last beat, then a late line.
      d0 = n_deq;
      push(lane_line);
      wait_idle("B1", 4'd4);
      chk("B_deq_once", 64'(n_deq - d0), 64'd1);
      repeat (5) tick();
      chk("B_no_deq_idle", 64'(n_deq - d0), 64'd1);
      push(rand_line());
      @(negedge clk);
      chk("B_deq_rise", 64'(q_deq), 64'd1);
      wait_idle("B2", 4'd5);

      // start after beat 4: rest of the line is dropped, next line sent intact.
      d0 = n_deq;
      push(lane_line); push(rand_line());
      wait_beats("C", 4);
      start = 1'b1; beat_ready = 1'b0; hold_rdy = 1;
      repeat (NB - 4) void'(sbq.pop_front());
      @(negedge clk);
      chk("C_deq_start_send", 64'(q_deq), 64'd0);
      tick();
      @(negedge clk);
      chk("C_valid", 64'(beat_valid), 64'd0);
      chk("C_busy", 64'(busy), 64'd0);
      chk("C_done", 64'(lines_done), 64'd0);
      chk("C_deq_start_idle", 64'(q_deq), 64'd0);
      tick();
      start = 1'b0; hold_rdy = 0; beat_ready = 1'b1;
      wait_idle("C", 4'd1);
      chk("C_deq_count", 64'(n_deq - d0), 64'd2);

      // Asynchronous reset between edges in the middle of a line.
      push(rand_line()); push(rand_line());
      wait_beats("D", 3);
      @(negedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("D_valid", 64'(beat_valid), 64'd0);
      chk("D_data", beat_data, 64'd0);
      chk("D_last", 64'(beat_last), 64'd0);
      chk("D_busy", 64'(busy), 64'd0);
      chk("D_done", 64'(lines_done), 64'd0);
      chk("D_deq", 64'(q_deq), 64'd0);
      sbq.delete(); lq.delete(); pend = 0; line_beats = 0;
      tick(); tick();
      reset = 1'b1;
      tick();

      // Counter wrap: 17 lines into a 4-bit counter.
      h0 = n_hs;
      for (int i = 0; i < 17; i++) push(rand_line());
      wait_idle("E", 4'd1);
      chk("E_beats", 64'(n_hs - h0), 64'(17 * NB));
      chk("E_sb_empty", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
